// File: rtl/viterbi_pkg.sv
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared constants for the K=7 Viterbi decoder blocks (branch
//               metric bank, add-compare-select array, traceback).
//               NUM_STATES  - trellis states
//               SM_W        - state-metric width
//               BM_W        - branch-metric width
//               INIT_METRIC - starting metric of every state except state 0
//               NORM_THRESH - amount removed from all metrics on normalisation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    localparam int NUM_STATES  = 64;
    localparam int SM_W        = 8;
    localparam int BM_W        = 2;
    localparam int INIT_METRIC = 64;
    localparam int NORM_THRESH = 1 << (SM_W - 1);

    // Frame-start metric of a state: state 0 is the known encoder start
    // state, every other state starts with a handicap.
    function automatic int sm_init_val(input int s);
        return (s == 0) ? 0 : INIT_METRIC;
    endfunction

endpackage : viterbi_pkg

`default_nettype wire

// File: rtl/acs_unit.sv
// ============================================================================
// Module      : acs_unit
// Description : Single add-compare-select element. Adds the branch metric of
//               each incoming path to its predecessor metric, keeps the
//               smaller sum (ties keep path 0), optionally removes the
//               normalisation offset and saturates to SM_W bits.
// Ports       : i_sm0 / i_sm1  predecessor metrics (p0 / p1)
//               i_bm0 / i_bm1  branch metrics of path 0 / path 1
//               i_norm         remove 2^(SM_W-1) from the survivor metric
//               o_sm           new state metric
//               o_dec          1 = predecessor p1 chosen
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acs_unit
    import viterbi_pkg::*;
#(
    parameter int SM_W = 8,
    parameter int BM_W = 2
) (
    input  logic [SM_W-1:0] i_sm0,
    input  logic [SM_W-1:0] i_sm1,
    input  logic [BM_W-1:0] i_bm0,
    input  logic [BM_W-1:0] i_bm1,
    input  logic            i_norm,
    output logic [SM_W-1:0] o_sm,
    output logic            o_dec
);

    localparam logic [SM_W:0] c_NORM = {2'b01, {(SM_W-1){1'b0}}};

    logic [SM_W:0] w_c0;
    logic [SM_W:0] w_c1;
    logic [SM_W:0] w_min;
    logic [SM_W:0] w_adj;
    logic          w_dec;

    // One extra bit of headroom so the sum never wraps before saturation.
    assign w_c0  = {1'b0, i_sm0} + {{(SM_W+1-BM_W){1'b0}}, i_bm0};
    assign w_c1  = {1'b0, i_sm1} + {{(SM_W+1-BM_W){1'b0}}, i_bm1};

    // Strict compare: an equal pair keeps predecessor p0.
    assign w_dec = (w_c1 < w_c0);
    assign w_min = w_dec ? w_c1 : w_c0;

    // Normalisation only fires when every operand has its MSB set, so the
    // survivor is always >= c_NORM and the subtraction cannot underflow.
    assign w_adj = i_norm ? (w_min - c_NORM) : w_min;

    assign o_sm  = w_adj[SM_W] ? {SM_W{1'b1}} : w_adj[SM_W-1:0];
    assign o_dec = w_dec;

endmodule : acs_unit

`default_nettype wire

// File: rtl/acs_64.sv
// ============================================================================
// Module      : acs_64
// Description : 64-state add-compare-select array with state-metric
//               registers, metric normalisation and minimum-metric finder.
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               start      frame start, reloads initial metrics (0 / 64)
//               in_valid   bm_flat carries one symbol's branch metrics
//               bm_flat    per state s: path_0 bm then path_1 bm, BM_W each
//               out_valid  registered metrics / decisions updated
//               dec        survivor decision per state (1 = p1)
//               sm_flat    registered state metrics, SM_W bits per state
//               best_state index of the smallest registered metric
//               norm_evt   normalisation applied on this update
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acs_64
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES = viterbi_pkg::NUM_STATES,
    parameter int SM_W       = viterbi_pkg::SM_W,
    parameter int BM_W       = viterbi_pkg::BM_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [NUM_STATES*2*BM_W-1:0]   bm_flat,
    output logic                           out_valid,
    output logic [NUM_STATES-1:0]          dec,
    output logic [NUM_STATES*SM_W-1:0]     sm_flat,
    output logic [$clog2(NUM_STATES)-1:0]  best_state,
    output logic                           norm_evt
);

    localparam int c_IDX_W = $clog2(NUM_STATES);

    logic [SM_W-1:0]       r_sm     [NUM_STATES];
    logic [NUM_STATES-1:0] r_dec;
    logic                  r_out_valid;
    logic                  r_norm_evt;

    logic [SM_W-1:0]       w_init   [NUM_STATES];
    logic [SM_W-1:0]       w_sm_op  [NUM_STATES];
    logic [SM_W-1:0]       w_sm_new [NUM_STATES];
    logic [NUM_STATES-1:0] w_dec;
    logic                  w_norm;
    logic [c_IDX_W-1:0]    w_best_idx;
    logic [SM_W-1:0]       w_best_val;

    // ------------------------------------------------------------------
    // Per-state datapath: operand mux, ACS element, output flattening
    // ------------------------------------------------------------------
    generate
        for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
            // Predecessors of s = {s[4:0],0} and {s[4:0],1}
            localparam int c_P0 = (2 * s) % NUM_STATES;
            localparam int c_P1 = c_P0 + 1;

            assign w_init[s]  = SM_W'(sm_init_val(s));

            // A start coinciding with a symbol must see the fresh metrics,
            // not whatever the previous frame left in the registers.
            assign w_sm_op[s] = start ? w_init[s] : r_sm[s];

            acs_unit #(
                .SM_W (SM_W),
                .BM_W (BM_W)
            ) u_acs (
                .i_sm0  (w_sm_op[c_P0]),
                .i_sm1  (w_sm_op[c_P1]),
                .i_bm0  (bm_flat[2*BM_W*s +: BM_W]),
                .i_bm1  (bm_flat[2*BM_W*s + BM_W +: BM_W]),
                .i_norm (w_norm),
                .o_sm   (w_sm_new[s]),
                .o_dec  (w_dec[s])
            );

            assign sm_flat[SM_W*s +: SM_W] = r_sm[s];
        end : g_state
    endgenerate

    // ------------------------------------------------------------------
    // Normalisation detect: all operand metrics in the upper half
    // ------------------------------------------------------------------
    always_comb begin
        w_norm = 1'b1;
        for (int s = 0; s < NUM_STATES; s++) begin
            w_norm = w_norm & w_sm_op[s][SM_W-1];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                r_sm[s] <= w_init[s];
            end
            r_dec       <= '0;
            r_out_valid <= 1'b0;
            r_norm_evt  <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_norm_evt  <= in_valid & w_norm;
            if (in_valid) begin
                for (int s = 0; s < NUM_STATES; s++) begin
                    r_sm[s] <= w_sm_new[s];
                end
                r_dec <= w_dec;
            end else if (start) begin
                // Decisions are left alone; only the metrics restart.
                for (int s = 0; s < NUM_STATES; s++) begin
                    r_sm[s] <= w_init[s];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Minimum finder on registered metrics; strict compare keeps the
    // lowest index on ties.
    // ------------------------------------------------------------------
    always_comb begin
        w_best_idx = '0;
        w_best_val = r_sm[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (r_sm[s] < w_best_val) begin
                w_best_val = r_sm[s];
                w_best_idx = c_IDX_W'(s);
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign norm_evt   = r_norm_evt;
    assign dec        = r_dec;
    assign best_state = w_best_idx;

endmodule : acs_64

`default_nettype wire

// File: tb/tb_acs_64.sv
// ============================================================================
// Module      : tb_acs_64
// Description : Self-checking bench for acs_64. A behavioural trellis model
//               pushes the expected result of every accepted symbol into a
//               scoreboard queue; a negedge monitor pops and compares on
//               each out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acs_64;

    localparam int NS  = 64;
    localparam int SMW = 8;
    localparam int BMW = 2;

    typedef struct {
        logic [NS*SMW-1:0] sm;
        logic [NS-1:0]     dec;
        logic [5:0]        best;
        logic              norm;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  in_valid;
    logic [NS*2*BMW-1:0]   bm_flat;
    logic                  out_valid;
    logic [NS-1:0]         dec;
    logic [NS*SMW-1:0]     sm_flat;
    logic [5:0]            best_state;
    logic                  norm_evt;

    exp_t                  sb[$];
    exp_t                  mon_e;
    int                    mdl_sm[NS];
    int                    n_chk     = 0;
    int                    n_err     = 0;
    int                    n_sym     = 0;
    int                    ov_seen   = 0;
    int                    norm_seen = 0;
    int                    norm_mdl  = 0;
    logic [NS*SMW-1:0]     init_flat;
    logic [NS*2*BMW-1:0]   bm_ones;
    logic [NS*2*BMW-1:0]   bm_twos;

    always #5 clk = ~clk;

    acs_64 #(
        .NUM_STATES (NS),
        .SM_W       (SMW),
        .BM_W       (BMW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .bm_flat    (bm_flat),
        .out_valid  (out_valid),
        .dec        (dec),
        .sm_flat    (sm_flat),
        .best_state (best_state),
        .norm_evt   (norm_evt)
    );

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int s = 0; s < NS; s++) mdl_sm[s] = (s == 0) ? 0 : 64;
    endtask

    // Reference trellis update for one cycle of stimulus
    task automatic mdl_step(input bit st, input bit v, input logic [NS*2*BMW-1:0] bm);
        int   op[NS];
        int   nw[NS];
        int   p0, c0, c1;
        bit   nrm;
        exp_t e;
        for (int s = 0; s < NS; s++) op[s] = st ? ((s == 0) ? 0 : 64) : mdl_sm[s];
        nrm = 1'b1;
        for (int s = 0; s < NS; s++) if (op[s] < 128) nrm = 1'b0;
        if (v) begin
            e.sm   = '0;
            e.dec  = '0;
            e.best = '0;
            for (int s = 0; s < NS; s++) begin
                p0 = (2 * s) % NS;
                c0 = op[p0]     + int'(bm[4*s +: 2]);
                c1 = op[p0 + 1] + int'(bm[4*s+2 +: 2]);
                e.dec[s] = (c1 < c0);
                nw[s]    = (c1 < c0) ? c1 : c0;
                if (nrm) nw[s] = nw[s] - 128;
                if (nw[s] > 255) nw[s] = 255;
            end
            for (int s = 0; s < NS; s++) begin
                e.sm[8*s +: 8] = nw[s][7:0];
                if (nw[s] < nw[e.best]) e.best = 6'(s);
                mdl_sm[s] = nw[s];
            end
            e.norm = nrm;
            if (nrm) norm_mdl++;
            n_sym++;
            sb.push_back(e);
        end else if (st) begin
            mdl_reset();
        end
    endtask

    task automatic drive(input bit st, input bit v, input logic [NS*2*BMW-1:0] bm);
        @(negedge clk);
        start    = st;
        in_valid = v;
        bm_flat  = bm;
        mdl_step(st, v, bm);
    endtask

    function automatic logic [NS*2*BMW-1:0] rand_bm();
        logic [NS*2*BMW-1:0] r;
        for (int i = 0; i < NS*2*BMW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Mid-frame reset with a symbol in flight that must be abandoned
    task automatic do_reset();
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        bm_flat  = rand_bm();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_sm",   sm_flat,    init_flat);
        check_eq("rst_dec",  dec,        '0);
        check_eq("rst_ov",   out_valid,  1'b0);
        check_eq("rst_best", best_state, 6'd0);
        @(negedge clk);
        in_valid = 1'b0;
        sb.delete();
        mdl_reset();
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                ov_seen++;
                if (norm_evt) norm_seen++;
                if (sb.size() == 0) begin
                    check_eq("ov_unexpected", out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sm",   sm_flat,    mon_e.sm);
                    check_eq("dec",  dec,        mon_e.dec);
                    check_eq("best", best_state, mon_e.best);
                    check_eq("norm", norm_evt,   mon_e.norm);
                end
            end else begin
                check_eq("norm_idle", norm_evt, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < NS; s++) init_flat[8*s +: 8] = (s == 0) ? 8'd0 : 8'd64;
        bm_ones = {(NS*2){2'b01}};
        bm_twos = {(NS*2){2'b10}};
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        bm_flat  = '0;
        mdl_reset();
        repeat (2) @(negedge clk);
        check_eq("init_sm",   sm_flat,    init_flat);
        check_eq("init_dec",  dec,        '0);
        check_eq("init_ov",   out_valid,  1'b0);
        check_eq("init_best", best_state, 6'd0);
        check_eq("init_norm", norm_evt,   1'b0);
        rst = 1'b0;

        // All-zero received stream
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        check_eq("zero_sm0",  sm_flat[7:0], 8'd0);
        check_eq("zero_dec0", dec[0],       1'b0);
        check_eq("zero_best", best_state,   6'd0);

        // Tie handling after reset
        do_reset();
        drive(1'b0, 1'b1, bm_ones);
        drive(1'b0, 1'b0, '0);
        check_eq("tie_sm0", sm_flat[7:0], 8'd1);
        check_eq("tie_dec", dec,          '0);

        // Normalisation under constant metric growth
        do_reset();
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, bm_twos);
        drive(1'b0, 1'b0, '0);

        // start with and without a symbol
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, rand_bm());
        drive(1'b1, 1'b1, rand_bm());
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, rand_bm());
        drive(1'b1, 1'b0, rand_bm());
        drive(1'b0, 1'b0, '0);
        check_eq("start_sm", sm_flat,   init_flat);
        check_eq("start_ov", out_valid, 1'b0);

        // Random stream
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_bm());
        end
        repeat (3) drive(1'b0, 1'b0, '0);

        check_eq("sb_drain",   sb.size(), 0);
        check_eq("ov_count",   ov_seen,   n_sym);
        check_eq("norm_count", norm_seen, norm_mdl);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule : tb_acs_64

`default_nettype wire
